// File: rtl/sign_adder_pkg.sv
// Shared constants and state encoding for the sign-magnitude serial adder datapath.
package sign_adder_pkg;

    localparam int MAG_W  = 7;
    localparam int WORD_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        SERIAL  = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Counter value at which the final (MSB) magnitude bit is processed.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MAG_W - 1);

endpackage

// File: rtl/mux7.sv
// 7-bit two-way mux used to order the operand magnitudes (sel=1 picks d1).
module mux7
    import sign_adder_pkg::*;
(
    input  logic             sel,
    input  logic [MAG_W-1:0] d0,
    input  logic [MAG_W-1:0] d1,
    output logic [MAG_W-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < MAG_W; gi = gi + 1) begin : g_bit
            assign y[gi] = sel ? d1[gi] : d0[gi];
        end
    endgenerate

endmodule

// File: rtl/sign_mag_serial_adder.sv
// Sign-magnitude adder: orders magnitudes in one cycle, then adds/subtracts
// bit-serially LSB first over MAG_W cycles; results behind a valid/ready handshake.
module sign_mag_serial_adder
    import sign_adder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] sum,
    output logic              ovf,
    output logic              busy
);

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] a_reg, b_reg, sum_reg;
    logic [MAG_W-1:0]  large_reg, small_reg, res_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              carry_reg, op_sub_reg, sign_reg, ovf_reg;

    logic              swap;
    logic [MAG_W-1:0]  large_mag, small_mag, final_mag;
    logic              s_bit, sum_bit, carry_next, last_bit;

    // Equal magnitudes keep A as the large operand.
    assign swap = b_reg[MAG_W-1:0] > a_reg[MAG_W-1:0];

    mux7 u_mux_large (
        .sel (swap),
        .d0  (a_reg[MAG_W-1:0]),
        .d1  (b_reg[MAG_W-1:0]),
        .y   (large_mag)
    );

    mux7 u_mux_small (
        .sel (swap),
        .d0  (b_reg[MAG_W-1:0]),
        .d1  (a_reg[MAG_W-1:0]),
        .y   (small_mag)
    );

    // Subtraction is large + ~small + 1; the +1 comes from the initial carry.
    assign s_bit      = small_reg[0] ^ op_sub_reg;
    assign sum_bit    = large_reg[0] ^ s_bit ^ carry_reg;
    assign carry_next = (large_reg[0] & s_bit) | (large_reg[0] & carry_reg) | (s_bit & carry_reg);
    assign final_mag  = {sum_bit, res_reg[MAG_W-1:1]};
    assign last_bit   = (cnt_reg == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = COMPARE;
            COMPARE: state_next = SERIAL;
            SERIAL:  if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            large_reg  <= '0;
            small_reg  <= '0;
            res_reg    <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            op_sub_reg <= 1'b0;
            sign_reg   <= 1'b0;
            sum_reg    <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                    end
                end
                COMPARE: begin
                    large_reg  <= large_mag;
                    small_reg  <= small_mag;
                    sign_reg   <= swap ? b_reg[WORD_W-1] : a_reg[WORD_W-1];
                    op_sub_reg <= a_reg[WORD_W-1] ^ b_reg[WORD_W-1];
                    carry_reg  <= a_reg[WORD_W-1] ^ b_reg[WORD_W-1];
                    cnt_reg    <= '0;
                end
                SERIAL: begin
                    large_reg <= large_reg >> 1;
                    small_reg <= small_reg >> 1;
                    res_reg   <= final_mag;
                    carry_reg <= carry_next;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_bit) begin
                        // A zero magnitude never carries a negative sign.
                        sum_reg <= {sign_reg & (final_mag != '0), final_mag};
                        ovf_reg <= ~op_sub_reg & carry_next;
                        cnt_reg <= '0;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == COMPARE) || (state_reg == SERIAL);
    assign sum       = sum_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_sign_mag_serial_adder.sv
// Self-checking bench for sign_mag_serial_adder: directed vectors, randomized
// operands against an integer-arithmetic reference model, backpressure and reset.
module tb_sign_mag_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       in_ready, out_valid, busy, ovf;
    logic [7:0] sum;

    int tests = 0;
    int fails = 0;

    sign_mag_serial_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: signed integer arithmetic on the decoded operands.
    function automatic void ref_add(input logic [7:0] x, input logic [7:0] y,
                                    output logic [7:0] s, output logic o);
        int   mx, my, vx, vy, r, m;
        logic sg;
        mx = int'(x[6:0]);
        my = int'(y[6:0]);
        vx = x[7] ? -mx : mx;
        vy = y[7] ? -my : my;
        if (x[7] == y[7]) begin
            m  = mx + my;
            o  = (m > 127);
            m  = m % 128;
            sg = x[7];
        end else begin
            r  = vx + vy;
            o  = 1'b0;
            sg = (r < 0);
            m  = (r < 0) ? -r : r;
        end
        if (m == 0) sg = 1'b0;
        s = {sg, m[6:0]};
    endfunction

    // Issues one operation from IDLE and completes it; lat = -1 on timeout.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb,
                          output logic [7:0] s, output logic o, output int lat);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        s = sum;
        o = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("[TB] op a=%02h b=%02h -> sum=%02h ovf=%0d lat=%0d", xa, xb, s, o, lat);
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({in_ready, out_valid, busy, ovf, sum} !== {4'b1000, 8'h00}) begin
            fails++;
            $display("FAIL reset_state: got rdy/vld/busy/ovf=%b sum=%02h, need 1000 sum=00",
                     {in_ready, out_valid, busy, ovf}, sum);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [7:0] va [8] = '{8'h05, 8'h05, 8'h89, 8'h64, 8'hE4, 8'h87, 8'h80, 8'h0A};
        logic [7:0] vb [8] = '{8'h03, 8'h89, 8'h05, 8'h32, 8'hB2, 8'h07, 8'h80, 8'h01};
        logic [7:0] es [8] = '{8'h08, 8'h84, 8'h84, 8'h16, 8'h96, 8'h00, 8'h00, 8'h0B};
        logic       eo [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] s;
        logic       o;
        int         lat;
        for (int k = 0; k < 8; k++) begin
            run_op(va[k], vb[k], s, o, lat);
            tests++;
            if (s !== es[k]) begin
                fails++;
                $display("FAIL directed_sum[%0d]: got %02h need %02h", k, s, es[k]);
            end
            tests++;
            if (o !== eo[k]) begin
                fails++;
                $display("FAIL directed_ovf[%0d]: got %b need %b", k, o, eo[k]);
            end
            tests++;
            if (lat != 8) begin
                fails++;
                $display("FAIL directed_latency[%0d]: got %0d need 8", k, lat);
            end
        end
    endtask

    task automatic test_busy();
        bit seen;
        in_valid = 1'b1;
        a = 8'h12;
        b = 8'h21;
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
            fails++;
            $display("FAIL busy_compare: got busy/rdy/vld=%b need 100", {busy, in_ready, out_valid});
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen || {busy, in_ready, sum} !== {2'b00, 8'h33}) begin
            fails++;
            $display("FAIL busy_done: got vld=%b busy/rdy=%b sum=%02h need 1 00 33",
                     out_valid, {busy, in_ready}, sum);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("[TB] op a=12 b=21 busy-phase check done");
    endtask

    task automatic test_backpressure();
        logic [7:0] xa, xb, es, s;
        logic       eo, o;
        int         lat;
        bit         seen;
        xa = 8'($urandom);
        xb = 8'($urandom);
        ref_add(xa, xb, es, eo);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL bp_out_valid: got timeout need out_valid");
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = ~in_valid;
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
            tests++;
            if ({sum, ovf, in_ready, out_valid} !== {es, eo, 2'b01}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got sum=%02h ovf=%b rdy/vld=%b need %02h %b 01",
                         k, sum, ovf, {in_ready, out_valid}, es, eo);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("[TB] op a=%02h b=%02h -> sum=%02h ovf=%0d (held 5 cycles)", xa, xb, es, eo);
        tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL bp_release: got rdy/vld=%b need 10", {in_ready, out_valid});
        end
        xa = 8'($urandom);
        xb = 8'($urandom);
        ref_add(xa, xb, es, eo);
        run_op(xa, xb, s, o, lat);
        tests++;
        if ({s, o} !== {es, eo} || lat != 8) begin
            fails++;
            $display("FAIL bp_next_op: got sum=%02h ovf=%b lat=%0d need %02h %b 8", s, o, lat, es, eo);
        end
    endtask

    task automatic test_random();
        logic [7:0] xa, xb, es, s;
        logic       eo, o;
        int         lat;
        for (int k = 0; k < 40; k++) begin
            xa = 8'($urandom);
            xb = 8'($urandom);
            if (k % 8 == 0) xb = {~xa[7], xa[6:0]};
            ref_add(xa, xb, es, eo);
            run_op(xa, xb, s, o, lat);
            tests++;
            if ({s, o} !== {es, eo} || lat != 8) begin
                fails++;
                $display("FAIL random[%0d] a=%02h b=%02h: got sum=%02h ovf=%b lat=%0d need %02h %b 8",
                         k, xa, xb, s, o, lat, es, eo);
            end
        end
    endtask

    task automatic test_midop_reset();
        logic [7:0] s;
        logic       o;
        int         lat;
        run_op(8'h05, 8'h03, s, o, lat);
        in_valid = 1'b1;
        a = 8'h33;
        b = 8'h11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if ({busy, sum} !== {1'b1, 8'h08}) begin
            fails++;
            $display("FAIL midop_pre: got busy=%b sum=%02h need 1 08", busy, sum);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, in_ready, busy, ovf, sum} !== {4'b0100, 8'h00}) begin
            fails++;
            $display("FAIL midop_reset: got vld/rdy/busy/ovf=%b sum=%02h need 0100 00",
                     {out_valid, in_ready, busy, ovf}, sum);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(8'h0A, 8'h01, s, o, lat);
        tests++;
        if ({s, o} !== {8'h0B, 1'b0} || lat != 8) begin
            fails++;
            $display("FAIL midop_after: got sum=%02h ovf=%b lat=%0d need 0b 0 8", s, o, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy();
        test_backpressure();
        test_random();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running need finish");
        $fatal(1, "watchdog expired");
    end

endmodule
